// File: rtl/fp_mul_core.sv
// fp_mul_core: iterative binary32 multiply core feeding specialJudge.
// Produces sign and raw {exp, frac} magnitude via a 24-step shift-add
// mantissa multiply, followed by a single normalize/round cycle.
// Zero/INF/NaN operands are not detected here; specialJudge overrides them
// using the registered operand magnitudes a_q/b_q.
// Build option: define FPMUL_RNE_EN for round-to-nearest-even; otherwise
// the result is truncated (round toward zero).
module fp_mul_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        sign,
    output logic [30:0] mag,
    output logic [30:0] a_q,
    output logic [30:0] b_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [23:0] mcand;
    logic [23:0] mplier;
    logic [47:0] acc;
    logic [4:0]  cnt;

    // Normalize/round datapath, consumed only in NORM
    logic        norm;
    logic [22:0] mant_raw;
    logic [22:0] mant;
    logic        carry;
    logic [9:0]  exp_sum;
    logic        exp_neg;
    logic [30:0] mag_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (cnt == 5'd23) begin
                    state_nxt = NORM;
                end
            end
            NORM: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Normalization select and rounding of the 48-bit product
    always_comb begin
        norm     = acc[47];
        mant_raw = norm ? acc[46:24] : acc[45:23];
`ifdef FPMUL_RNE_EN
        begin
            logic        guard;
            logic        sticky;
            logic [23:0] rnd;
            guard  = norm ? acc[23] : acc[22];
            sticky = norm ? (|acc[22:0]) : (|acc[21:0]);
            rnd    = {1'b0, mant_raw} + {23'd0, (guard & (sticky | mant_raw[0]))};
            // Carry out means the significand became 10.000..0; after the
            // right shift the fraction is all zeros, which rnd[22:0] already is.
            carry  = rnd[23];
            mant   = rnd[22:0];
        end
`else
        carry = 1'b0;
        mant  = mant_raw;
`endif
        exp_sum = {2'b00, a_q[30:23]} + {2'b00, b_q[30:23]} - 10'd127
                  + {9'd0, norm} + {9'd0, carry};
        exp_neg = exp_sum[9];
        if (!exp_neg && (exp_sum >= 10'd255)) begin
            mag_nxt = 31'h7F800000;
        end else if (exp_neg || (exp_sum == 10'd0)) begin
            mag_nxt = '0;
        end else begin
            mag_nxt = {exp_sum[7:0], mant};
        end
    end

`ifndef FPMUL_RNE_EN
    // Low product bits only matter for rounding
    logic unused_lo;
    assign unused_lo = ^acc[22:0];
`endif

    // Operand capture, shift-add multiply and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign   <= 1'b0;
            mag    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign   <= a[31] ^ b[31];
                        a_q    <= a[30:0];
                        b_q    <= b[30:0];
                        mcand  <= {(a[30:23] != 8'd0), a[22:0]};
                        mplier <= {(b[30:23] != 8'd0), b[22:0]};
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MUL: begin
                    if (mplier[cnt]) begin
                        acc <= acc + ({24'd0, mcand} << cnt);
                    end
                    cnt <= cnt + 5'd1;
                end
                NORM: begin
                    mag <= mag_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_core.sv
// Directed bench for fp_mul_core with an expected-result queue.
// Honours FPMUL_RNE_EN the same way the core does.
module tb_fp_mul_core;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic        sign;
    logic [30:0] mag;
    logic [30:0] a_q;
    logic [30:0] b_q;

    fp_mul_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sign  (sign),
        .mag   (mag),
        .a_q   (a_q),
        .b_q   (b_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [30:0] m;
        logic [30:0] aq;
        logic [30:0] bq;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          errors   = 0;
    int unsigned cyc      = 0;
    int unsigned done_cnt = 0;
    int unsigned e0       = 0;

    // Edge counter and done-pulse counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Reference: full 48-bit multiply, then normalize/round
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
        logic [23:0] mx;
        logic [23:0] my;
        logic [47:0] p;
        logic [22:0] mt;
        int          e;
        logic        sg;
        mx = {(x[30:23] != 8'd0), x[22:0]};
        my = {(y[30:23] != 8'd0), y[22:0]};
        p  = {24'd0, mx} * {24'd0, my};
        e  = int'(x[30:23]) + int'(y[30:23]) - 127;
        sg = x[31] ^ y[31];
        if (p[47]) begin
            mt = p[46:24];
            e++;
        end else begin
            mt = p[45:23];
        end
`ifdef FPMUL_RNE_EN
        begin
            logic        g;
            logic        s;
            logic [23:0] r;
            g = p[47] ? p[23] : p[22];
            s = p[47] ? (|p[22:0]) : (|p[21:0]);
            if (g && (s || mt[0])) begin
                r  = {1'b0, mt} + 24'd1;
                mt = r[22:0];
                if (r[23]) e++;
            end
        end
`endif
        if (e >= 255) return {sg, 31'h7F800000};
        if (e <= 0)   return {sg, 31'h0};
        return {sg, e[7:0], mt};
    endfunction

    // Drive one start strobe (accepted at the next edge) and queue the expectation
    task automatic launch(input logic [31:0] aa, input logic [31:0] bb, input logic [30:0] m_exp);
        exp_t item;
        @(negedge clk);
        a     = aa;
        b     = bb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
        item.s  = aa[31] ^ bb[31];
        item.m  = m_exp;
        item.aq = aa[30:0];
        item.bq = bb[30:0];
        sb.push_back(item);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Wait (bounded) for done, then check latency and pop/compare the result
    task automatic wait_done(input string tag);
        int   k;
        exp_t item;
        k = 0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
        item = sb.pop_front();
        if (!done) begin
            chk({tag, "_timeout"}, {31'd0, done}, 32'd1);
        end else begin
            chk({tag, "_latency"}, cyc - e0, 32'd25);
            chk({tag, "_sign"}, {31'd0, sign}, {31'd0, item.s});
            chk({tag, "_mag"},  {1'b0, mag},  {1'b0, item.m});
            chk({tag, "_a_q"},  {1'b0, a_q},  {1'b0, item.aq});
            chk({tag, "_b_q"},  {1'b0, b_q},  {1'b0, item.bq});
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                          input logic [30:0] m_exp);
        launch(aa, bb, m_exp);
        wait_done(tag);
        @(negedge clk);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_end"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int unsigned d0;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rm;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sign", {31'd0, sign}, 32'd0);
        chk("rst_mag",  {1'b0, mag},  32'd0);
        chk("rst_a_q",  {1'b0, a_q},  32'd0);
        chk("rst_b_q",  {1'b0, b_q},  32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed operations
        run_op("mul_2x3",     32'h40000000, 32'h40400000, 31'h40C00000);
        run_op("mul_1p5xm1p5", 32'h3FC00000, 32'hBFC00000, 31'h40100000);
`ifdef FPMUL_RNE_EN
        run_op("round_tie",   32'h3F800001, 32'h3FC00000, 31'h3FC00002);
`else
        run_op("round_tie",   32'h3F800001, 32'h3FC00000, 31'h3FC00001);
`endif
        run_op("overflow",    32'h7F000000, 32'h7F000000, 31'h7F800000);
        run_op("underflow",   32'h00800000, 32'h00800000, 31'h00000000);

        // Random normal-range operands against the reference
        for (int i = 0; i < 4; i++) begin
            ra = {$urandom_range(1, 0) == 1, 8'($urandom_range(100, 154)), 23'($urandom)};
            rb = {$urandom_range(1, 0) == 1, 8'($urandom_range(100, 154)), 23'($urandom)};
            rm = model(ra, rb);
            run_op($sformatf("rand%0d", i), ra, rb, rm[30:0]);
        end

        // Start while busy is ignored: one done, first operands' result
        d0 = done_cnt;
        launch(32'h40000000, 32'h40400000, 31'h40C00000);
        repeat (9) @(negedge clk);
        a     = 32'h40800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        repeat (30) @(negedge clk);
        chk("busy_start_one_done", done_cnt - d0, 32'd1);
        chk("busy_start_idle", {31'd0, busy}, 32'd0);

        // Start held during DONE: ignored there, accepted on the next IDLE cycle
        launch(32'h40000000, 32'h40400000, 31'h40C00000);
        wait_done("done_start_first");
        a     = 32'h40400000;
        b     = 32'h3FC00000;
        start = 1'b1;
        @(negedge clk);
        chk("done_start_ignored", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
        chk("done_start_accepted", {31'd0, busy}, 32'd1);
        sb.push_back('{s: 1'b0, m: 31'h40900000, aq: 31'h40400000, bq: 31'h3FC00000});
        wait_done("done_start_second");
        @(negedge clk);

        // Reset mid-MUL aborts with no later done
        launch(32'h3FC00000, 32'hBFC00000, 31'h40100000);
        repeat (11) @(negedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_sign", {31'd0, sign}, 32'd0);
        chk("midrst_mag",  {1'b0, mag},  32'd0);
        chk("midrst_a_q",  {1'b0, a_q},  32'd0);
        chk("midrst_b_q",  {1'b0, b_q},  32'd0);
        d0 = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 32'd0);
        chk("midrst_idle", {31'd0, busy}, 32'd0);
        chk("midrst_mag_hold", {1'b0, mag}, 32'd0);

        // Recovery after reset
        run_op("after_rst", 32'h40000000, 32'h40400000, 31'h40C00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
